decoder_nx2n_seq: RTL and testbench

Parametrised, registered N-to-2^N decoder with an auto-advancing scan mode. It generalises the team's fixed 3x8 combinational decoder: arbitrary select width, registered one-hot outputs, a thermometer mode, and an internal scan counter with programmable dwell. Typical use is row/bank-select generation and time-multiplexed strobe sequencing, for example display scanning or round-robin enable fan-out.

---
 rtl/decoder_nx2n_seq.sv | 96 +++++++++
 tb/tb_decoder_nx2n_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/decoder_nx2n_seq.sv
// Registered N-to-2**N decoder with thermometer, hold and auto-advancing scan modes.
// Scan index advances every DWELL enabled SCAN cycles; wrap pulses when it returns to 0.
module decoder_nx2n_seq #(
  parameter int N     = 3,
  parameter int DWELL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              EN,
  input  logic [1:0]        mode,
  input  logic [N-1:0]      sel,
  input  logic              load,
  output logic [2**N-1:0]   y,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int W  = 2**N;
  localparam int CW = (DWELL < 1) ? 1 : $clog2(DWELL + 1);

  typedef enum logic [1:0] {
    MODE_DECODE = 2'b00,
    MODE_SCAN   = 2'b01,
    MODE_THERMO = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  logic [CW-1:0] cnt, cnt_nxt;
  logic [W-1:0]  y_nxt;
  logic [N-1:0]  idx_nxt;
  logic          wrap_nxt;

  function automatic logic [W-1:0] one_hot(input logic [N-1:0] i);
    logic [W-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [W-1:0] thermo(input logic [N-1:0] i);
    logic [W-1:0] v;
    for (int b = 0; b < W; b++) v[b] = (b <= int'(i));
    return v;
  endfunction

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    y_nxt    = y;
    idx_nxt  = idx;
    cnt_nxt  = cnt;
    wrap_nxt = 1'b0;
    if (!EN) begin
      y_nxt = '0;
    end else begin
      case (mode_e'(mode))
        MODE_DECODE: y_nxt = one_hot(sel);
        MODE_THERMO: y_nxt = thermo(sel);
        MODE_HOLD:   ;
        MODE_SCAN: begin
          if (load) begin
            idx_nxt = sel;
            cnt_nxt = '0;
            y_nxt   = one_hot(sel);
          end else begin
            // y shows the pre-advance index, so it trails idx by one cycle.
            y_nxt = one_hot(idx);
            if (cnt == CW'(DWELL - 1)) begin
              cnt_nxt  = '0;
              idx_nxt  = idx + N'(1);
              wrap_nxt = (idx == '1);
            end else begin
              cnt_nxt = cnt + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y    <= '0;
      idx  <= '0;
      cnt  <= '0;
      wrap <= 1'b0;
    end else begin
      y    <= y_nxt;
      idx  <= idx_nxt;
      cnt  <= cnt_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_decoder_nx2n_seq.sv
// Directed bench: a table-driven DECODE/THERMO sweep on an N=3 instance and
// hand-written SCAN sequences on an N=2, DWELL=3 instance.
module tb_decoder_nx2n_seq;

  localparam logic [1:0] M_DEC = 2'b00, M_SCAN = 2'b01, M_THR = 2'b10, M_HOLD = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       d_en = 1'b0;
  logic [1:0] d_mode = M_DEC;
  logic [2:0] d_sel = '0;
  logic       d_load = 1'b0;
  logic [7:0] d_y;
  logic [2:0] d_idx;
  logic       d_wrap;

  logic       s_en = 1'b0;
  logic [1:0] s_mode = M_HOLD;
  logic [1:0] s_sel = '0;
  logic       s_load = 1'b0;
  logic [3:0] s_y;
  logic [1:0] s_idx;
  logic       s_wrap;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decoder_nx2n_seq #(.N(3), .DWELL(1)) u_dec (
    .clk(clk), .rst_n(rst_n), .EN(d_en), .mode(d_mode), .sel(d_sel),
    .load(d_load), .y(d_y), .idx(d_idx), .wrap(d_wrap)
  );

  decoder_nx2n_seq #(.N(2), .DWELL(3)) u_scan (
    .clk(clk), .rst_n(rst_n), .EN(s_en), .mode(s_mode), .sel(s_sel),
    .load(s_load), .y(s_y), .idx(s_idx), .wrap(s_wrap)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic [2:0] sel;
    logic [7:0] exp_y;
  } dec_vec_t;

  dec_vec_t dv[16];

  logic [1:0] exp_idx[12]  = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
  logic       exp_wrap[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
  logic [3:0] exp_sy[12]   = '{1, 1, 1, 2, 2, 2, 4, 4, 4, 8, 8, 8};

  initial begin
    dv[0]  = '{1'b1, M_DEC,  3'd0, 8'h01};
    dv[1]  = '{1'b1, M_DEC,  3'd1, 8'h02};
    dv[2]  = '{1'b1, M_DEC,  3'd2, 8'h04};
    dv[3]  = '{1'b1, M_DEC,  3'd3, 8'h08};
    dv[4]  = '{1'b1, M_DEC,  3'd4, 8'h10};
    dv[5]  = '{1'b1, M_DEC,  3'd5, 8'h20};
    dv[6]  = '{1'b1, M_DEC,  3'd6, 8'h40};
    dv[7]  = '{1'b1, M_DEC,  3'd7, 8'h80};
    dv[8]  = '{1'b0, M_DEC,  3'd5, 8'h00};
    dv[9]  = '{1'b1, M_THR,  3'd0, 8'h01};
    dv[10] = '{1'b1, M_THR,  3'd3, 8'h0F};
    dv[11] = '{1'b1, M_THR,  3'd7, 8'hFF};
    dv[12] = '{1'b1, M_HOLD, 3'd2, 8'hFF};
    dv[13] = '{1'b1, M_THR,  3'd5, 8'h3F};
    dv[14] = '{1'b0, M_THR,  3'd5, 8'h00};
    dv[15] = '{1'b1, M_DEC,  3'd3, 8'h08};

    // Reset values while rst_n is held low.
    step();
    check("rst_y",    {28'd0, s_y}, 32'h0);
    check("rst_idx",  {30'd0, s_idx}, 32'h0);
    check("rst_wrap", {31'd0, s_wrap}, 32'h0);
    check("rst_dy",   {24'd0, d_y}, 32'h0);
    step();
    rst_n = 1'b1;

    // DECODE / THERMO / HOLD / enable table on the N=3 instance.
    for (int i = 0; i < 16; i++) begin
      d_en = dv[i].en; d_mode = dv[i].mode; d_sel = dv[i].sel;
      step();
      check($sformatf("dec_vec%0d_y", i), {24'd0, d_y}, {24'd0, dv[i].exp_y});
    end
    check("dec_idx_hold", {29'd0, d_idx}, 32'h0);

    // SCAN from reset state, DWELL=3, N=2.
    s_en = 1'b1; s_mode = M_SCAN;
    check("scan_idx_start", {30'd0, s_idx}, 32'h0);
    for (int k = 0; k < 12; k++) begin
      step();
      check($sformatf("scan%0d_idx", k),  {30'd0, s_idx},  {30'd0, exp_idx[k]});
      check($sformatf("scan%0d_wrap", k), {31'd0, s_wrap}, {31'd0, exp_wrap[k]});
      check($sformatf("scan%0d_y", k),    {28'd0, s_y},    {28'd0, exp_sy[k]});
    end

    // Advance to idx=3 on its last dwell cycle, then load in the would-wrap cycle.
    repeat (11) step();
    check("pre_load_idx", {30'd0, s_idx}, 32'd3);
    s_load = 1'b1; s_sel = 2'd2;
    step();
    s_load = 1'b0; s_sel = 2'd0;
    check("load_idx",  {30'd0, s_idx},  32'd2);
    check("load_wrap", {31'd0, s_wrap}, 32'd0);
    check("load_y",    {28'd0, s_y},    32'h4);
    step();
    step();
    check("load_dwell_idx", {30'd0, s_idx}, 32'd2);
    check("load_dwell_y",   {28'd0, s_y},   32'h4);
    step();
    check("load_adv_idx", {30'd0, s_idx}, 32'd3);

    // idx=3, dwell=0: one SCAN cycle, then HOLD for 5 cycles.
    step();
    s_mode = M_HOLD;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("hold%0d_y", k),   {28'd0, s_y},   32'h8);
      check($sformatf("hold%0d_idx", k), {30'd0, s_idx}, 32'd3);
    end
    s_mode = M_SCAN;
    step();
    check("resume_idx", {30'd0, s_idx}, 32'd3);
    step();
    check("resume_wrap_idx", {30'd0, s_idx},  32'd0);
    check("resume_wrap",     {31'd0, s_wrap}, 32'd1);
    check("resume_wrap_y",   {28'd0, s_y},    32'h8);
    step();
    check("resume_y0",    {28'd0, s_y},    32'h1);
    check("resume_wrap0", {31'd0, s_wrap}, 32'd0);

    // EN low for 2 cycles: y clears, idx and dwell count freeze (idx=0, dwell=1).
    s_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      check($sformatf("en_off%0d_y", k),   {28'd0, s_y},   32'h0);
      check($sformatf("en_off%0d_idx", k), {30'd0, s_idx}, 32'd0);
    end
    s_en = 1'b1;
    step();
    check("reen_y",   {28'd0, s_y},   32'h1);
    check("reen_idx", {30'd0, s_idx}, 32'd0);
    step();
    check("reen_adv_idx", {30'd0, s_idx}, 32'd1);

    // Asynchronous reset mid-cycle while scanning.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_y",    {28'd0, s_y},    32'h0);
    check("async_rst_idx",  {30'd0, s_idx},  32'h0);
    check("async_rst_wrap", {31'd0, s_wrap}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_y",   {28'd0, s_y},   32'h1);
    check("post_rst_idx", {30'd0, s_idx}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
